// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg
//   Shared constants and types for the Ethernet RX FCS checker and the
//   byte-wise CRC-32 engine that is also used by the TX path.
//
//   CRC_POLY    : generator polynomial (normal, MSB-first form)
//   CRC_INIT    : CRC register seed at frame start
//   CRC_RESIDUE : register value after a frame plus its own FCS is absorbed
//   FCS_BYTES   : length of the FCS trailer / depth of the strip delay line
//   rx_state_t  : frame FSM states
package eth_rx_pkg;

    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

    localparam int unsigned FCS_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } rx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte
//   Combinational one-byte step of the Ethernet CRC-32. The register is kept
//   in MSB-first form while the data byte enters LSB first (reflected input),
//   which is the same bit order the TX engine uses.
//
//   Ports:
//     crc      in  32  current CRC register
//     dat      in   8  data byte
//     crc_next out 32  CRC register after absorbing dat
module eth_crc32_byte
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  dat,
    output logic [31:0] crc_next
);

    logic [7:0] bits;
    logic       fb;

    always_comb begin
        crc_next = crc;
        bits     = dat;
        fb       = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            // Feedback combines the register MSB with the next data bit,
            // taken LSB first.
            fb       = crc_next[31] ^ bits[0];
            crc_next = {crc_next[30:0], 1'b0};
            if (fb) begin
                crc_next = crc_next ^ CRC_POLY;
            end
            bits = bits >> 1;
        end
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check
//   Receive-side FCS checker. Computes the Ethernet CRC-32 over each frame
//   including its FCS, compares the residue, strips the FCS through a
//   4-byte delay line and reports per-frame status.
//
//   Optional build macro: ETH_RX_STATS_EN enables saturating good/bad frame
//   counters; without it o_good_cnt/o_bad_cnt are tied to zero.
//
//   Parameters:
//     MIN_LEN  minimum legal length incl. FCS (shorter -> o_runt)
//     MAX_LEN  maximum legal length incl. FCS (longer  -> o_oversize)
//     LEN_W    width of the byte counter and o_len
//
//   Ports:
//     clk, nrst            clock, asynchronous active-low reset
//     i_valid/i_dat        input byte stream (preamble/SFD already removed)
//     i_last               final FCS byte, only meaningful with i_valid
//     i_err                PHY rx_er, sampled with i_valid
//     o_valid/o_dat        payload bytes, FCS removed
//     o_first/o_last       first / last payload byte markers
//     o_done               one-cycle frame status strobe
//     o_fcs_ok, o_runt,
//     o_oversize, o_phy_err,
//     o_len                frame status, valid with o_done (held until next)
//     o_good_cnt/o_bad_cnt frame statistics (ETH_RX_STATS_EN)
module eth_rx_fcs_check
    import eth_rx_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_valid,
    input  logic [7:0]       i_dat,
    input  logic             i_last,
    input  logic             i_err,
    output logic             o_valid,
    output logic [7:0]       o_dat,
    output logic             o_first,
    output logic             o_last,
    output logic             o_done,
    output logic             o_fcs_ok,
    output logic             o_runt,
    output logic             o_oversize,
    output logic             o_phy_err,
    output logic [LEN_W-1:0] o_len,
    output logic [15:0]      o_good_cnt,
    output logic [15:0]      o_bad_cnt
);

    localparam int unsigned DLY_W = FCS_BYTES * 8;

    rx_state_t        state;
    logic [31:0]      crc;
    logic [31:0]      crc_seed;
    logic [31:0]      crc_next;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_base;
    logic [LEN_W-1:0] cnt_next;
    logic [DLY_W-1:0] dly;
    logic             err_seen;

    logic             frame_end;
    logic             phy_next;
    logic             fcs_ok_next;
    logic             runt_next;
    logic             over_next;
    logic             fill_done;
    logic             first_out;

    eth_crc32_byte u_crc (
        .crc      (crc_seed),
        .dat      (i_dat),
        .crc_next (crc_next)
    );

    // Per-beat next values. In IDLE the frame restarts from the CRC seed,
    // a zero count and a clean error flag instead of the previous frame's
    // leftovers.
    always_comb begin
        frame_end   = i_valid & i_last;
        crc_seed    = (state == IDLE) ? CRC_INIT : crc;
        cnt_base    = (state == IDLE) ? '0 : cnt;
        cnt_next    = (&cnt_base) ? cnt_base : cnt_base + LEN_W'(1);
        phy_next    = ((state == IDLE) ? 1'b0 : err_seen) | i_err;
        fcs_ok_next = (crc_next == CRC_RESIDUE);
        runt_next   = (32'(cnt_next) < MIN_LEN);
        over_next   = (32'(cnt_next) > MAX_LEN);
        fill_done   = (cnt_next == LEN_W'(FCS_BYTES));
        // The first byte leaves the delay line on the beat after it filled.
        first_out   = (cnt == LEN_W'(FCS_BYTES));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            crc        <= CRC_INIT;
            cnt        <= '0;
            dly        <= '0;
            err_seen   <= 1'b0;
            o_valid    <= 1'b0;
            o_dat      <= '0;
            o_first    <= 1'b0;
            o_last     <= 1'b0;
            o_done     <= 1'b0;
            o_fcs_ok   <= 1'b0;
            o_runt     <= 1'b0;
            o_oversize <= 1'b0;
            o_phy_err  <= 1'b0;
            o_len      <= '0;
        end else begin
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
            o_done  <= 1'b0;

            if (i_valid) begin
                crc      <= crc_next;
                cnt      <= cnt_next;
                err_seen <= phy_next;
                dly      <= {dly[DLY_W-9:0], i_dat};

                case (state)
                    IDLE: begin
                        state <= FILL;
                    end
                    FILL: begin
                        if (fill_done) begin
                            state <= STREAM;
                        end
                    end
                    STREAM: begin
                        o_valid <= 1'b1;
                        o_dat   <= dly[DLY_W-1 -: 8];
                        o_first <= first_out;
                        o_last  <= i_last;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase

                // The final beat overrides any FILL/STREAM transition above.
                if (i_last) begin
                    state      <= IDLE;
                    o_done     <= 1'b1;
                    o_fcs_ok   <= fcs_ok_next;
                    o_runt     <= runt_next;
                    o_oversize <= over_next;
                    o_phy_err  <= phy_next;
                    o_len      <= cnt_next;
                end
            end
        end
    end

`ifdef ETH_RX_STATS_EN
    logic frame_good;

    always_comb begin
        frame_good = fcs_ok_next & ~runt_next & ~over_next & ~phy_next;
    end

    // Counters move on the same edge that raises o_done, so they already
    // include the frame while its status is presented.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_good_cnt <= '0;
            o_bad_cnt  <= '0;
        end else if (frame_end) begin
            if (frame_good) begin
                if (o_good_cnt != '1) begin
                    o_good_cnt <= o_good_cnt + 16'd1;
                end
            end else begin
                if (o_bad_cnt != '1) begin
                    o_bad_cnt <= o_bad_cnt + 16'd1;
                end
            end
        end
    end
`else
    logic unused_frame_end;

    always_comb begin
        unused_frame_end = frame_end;
    end

    assign o_good_cnt = '0;
    assign o_bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb_eth_rx_fcs_check
//   Self-checking bench for eth_rx_fcs_check. Two instances share the input
//   stream: one with default parameters and one with MIN_LEN=0. Frames are
//   built from random bytes with a CRC appended by a reflected (LSB-first)
//   software CRC-32; expected payload and status come from that model.
module tb_eth_rx_fcs_check;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned MIN_A   = 64;
    localparam int unsigned MIN_B   = 0;
    localparam int unsigned MAX_LEN = 1518;

    logic             clk = 1'b0;
    logic             nrst;
    logic             i_valid;
    logic [7:0]       i_dat;
    logic             i_last;
    logic             i_err;

    logic             v_a, f_a, l_a, d_a, ok_a, rn_a, ov_a, pe_a;
    logic [7:0]       dat_a;
    logic [LEN_W-1:0] len_a;
    logic [15:0]      gc_a, bc_a;
    logic             v_b, f_b, l_b, d_b, ok_b, rn_b, ov_b, pe_b;
    logic [7:0]       dat_b;
    logic [LEN_W-1:0] len_b;
    logic [15:0]      gc_b, bc_b;

    always #5 clk = ~clk;

    eth_rx_fcs_check #(.MIN_LEN(MIN_A), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_dut_a (
        .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_dat(i_dat), .i_last(i_last), .i_err(i_err),
        .o_valid(v_a), .o_dat(dat_a), .o_first(f_a), .o_last(l_a), .o_done(d_a),
        .o_fcs_ok(ok_a), .o_runt(rn_a), .o_oversize(ov_a), .o_phy_err(pe_a), .o_len(len_a),
        .o_good_cnt(gc_a), .o_bad_cnt(bc_a)
    );

    eth_rx_fcs_check #(.MIN_LEN(MIN_B), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_dut_b (
        .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_dat(i_dat), .i_last(i_last), .i_err(i_err),
        .o_valid(v_b), .o_dat(dat_b), .o_first(f_b), .o_last(l_b), .o_done(d_b),
        .o_fcs_ok(ok_b), .o_runt(rn_b), .o_oversize(ov_b), .o_phy_err(pe_b), .o_len(len_b),
        .o_good_cnt(gc_b), .o_bad_cnt(bc_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       inst;
        logic       first;
        logic       last;
        logic [7:0] dat;
    } pay_t;

    typedef struct packed {
        logic             inst;
        logic             fcs_ok;
        logic             runt;
        logic             over;
        logic             phy;
        logic [LEN_W-1:0] len;
    } st_t;

    pay_t       pay_q[$];
    st_t        st_q[$];
    logic [7:0] frm[$];
    int         err_idx = -1;
    int         good_m[2];
    int         bad_m[2];

    always @(negedge clk) begin
        if (v_a) pay_q.push_back(pay_t'{inst: 1'b0, first: f_a, last: l_a, dat: dat_a});
        if (v_b) pay_q.push_back(pay_t'{inst: 1'b1, first: f_b, last: l_b, dat: dat_b});
        if (d_a) st_q.push_back(st_t'{inst: 1'b0, fcs_ok: ok_a, runt: rn_a, over: ov_a, phy: pe_a, len: len_a});
        if (d_b) st_q.push_back(st_t'{inst: 1'b1, fcs_ok: ok_b, runt: rn_b, over: ov_b, phy: pe_b, len: len_b});
    end

    // Standard reflected CRC-32 over frm[0..n-1].
    function automatic logic [31:0] crc_refl(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic make_good(input int ndata);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < ndata; i++) frm.push_back(8'($urandom));
        fcs = ~crc_refl(ndata);
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    task automatic idle_beat();
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'($urandom);
        i_err   = 1'($urandom);
        i_dat   = 8'($urandom);
    endtask

    task automatic send(input int gap_max, input int rst_at);
        for (int i = 0; i < frm.size(); i++) begin
            if (i > 0 && gap_max > 0) begin
                repeat ($urandom_range(1, gap_max)) idle_beat();
            end
            if (i == rst_at) begin
                @(negedge clk);
                i_valid = 1'b0;
                i_last  = 1'b0;
                nrst    = 1'b0;
                repeat (2) @(negedge clk);
                chk("rst_valid", {31'h0, v_a}, 32'h0);
                chk("rst_len", {16'h0, len_a}, 32'h0);
                nrst = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            @(negedge clk);
            i_valid = 1'b1;
            i_dat   = frm[i];
            i_last  = (i == frm.size() - 1);
            i_err   = (i == err_idx);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_err   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string nm, input bit expect_done);
        int          n, n_pay, j, d, minl;
        logic        ok, runt, over, phy;
        logic [31:0] len;
        n     = frm.size();
        n_pay = (n > 4) ? n - 4 : 0;
        ok    = (crc_refl(n) == 32'hDEBB_20E3);
        over  = (n > int'(MAX_LEN));
        phy   = (err_idx >= 0 && err_idx < n);
        len   = (n > 65535) ? 32'd65535 : 32'(n);
        for (int k = 0; k < 2; k++) begin
            minl = (k == 0) ? int'(MIN_A) : int'(MIN_B);
            runt = (n < minl);
            if (expect_done) begin
                j = 0;
                foreach (pay_q[p]) begin
                    if (pay_q[p].inst == 1'(k)) begin
                        if (j < n_pay) begin
                            chk($sformatf("%s.i%0d.dat%0d", nm, k, j), {24'h0, pay_q[p].dat}, {24'h0, frm[j]});
                            chk($sformatf("%s.i%0d.first%0d", nm, k, j), {31'h0, pay_q[p].first}, {31'h0, 1'(j == 0)});
                            chk($sformatf("%s.i%0d.last%0d", nm, k, j), {31'h0, pay_q[p].last}, {31'h0, 1'(j == n_pay - 1)});
                        end
                        j++;
                    end
                end
                chk($sformatf("%s.i%0d.pay_cnt", nm, k), 32'(j), 32'(n_pay));
            end
            d = 0;
            foreach (st_q[s]) begin
                if (st_q[s].inst == 1'(k)) begin
                    chk($sformatf("%s.i%0d.fcs_ok", nm, k), {31'h0, st_q[s].fcs_ok}, {31'h0, ok});
                    chk($sformatf("%s.i%0d.runt", nm, k), {31'h0, st_q[s].runt}, {31'h0, runt});
                    chk($sformatf("%s.i%0d.oversize", nm, k), {31'h0, st_q[s].over}, {31'h0, over});
                    chk($sformatf("%s.i%0d.phy_err", nm, k), {31'h0, st_q[s].phy}, {31'h0, phy});
                    chk($sformatf("%s.i%0d.len", nm, k), {16'h0, st_q[s].len}, len);
                    d++;
                end
            end
            chk($sformatf("%s.i%0d.done_cnt", nm, k), 32'(d), expect_done ? 32'd1 : 32'd0);
            if (expect_done) begin
                if (ok && !runt && !over && !phy) good_m[k]++;
                else bad_m[k]++;
            end else begin
                good_m[k] = 0;
                bad_m[k]  = 0;
            end
        end
        pay_q.delete();
        st_q.delete();
    endtask

    task automatic check_stats(input string nm);
        int eg[2], eb[2];
        for (int k = 0; k < 2; k++) begin
`ifdef ETH_RX_STATS_EN
            eg[k] = good_m[k];
            eb[k] = bad_m[k];
`else
            eg[k] = 0;
            eb[k] = 0;
`endif
        end
        chk({nm, ".i0.good_cnt"}, {16'h0, gc_a}, 32'(eg[0]));
        chk({nm, ".i0.bad_cnt"}, {16'h0, bc_a}, 32'(eb[0]));
        chk({nm, ".i1.good_cnt"}, {16'h0, gc_b}, 32'(eg[1]));
        chk({nm, ".i1.bad_cnt"}, {16'h0, bc_b}, 32'(eb[1]));
    endtask

    initial begin
        int nd;
        nrst    = 1'b0;
        i_valid = 1'b0;
        i_dat   = '0;
        i_last  = 1'b0;
        i_err   = 1'b0;
        good_m  = '{0, 0};
        bad_m   = '{0, 0};
        repeat (3) @(negedge clk);
        chk("reset.valid", {31'h0, v_a}, 32'h0);
        chk("reset.done", {31'h0, d_a}, 32'h0);
        chk("reset.fcs_ok", {31'h0, ok_a}, 32'h0);
        chk("reset.len", {16'h0, len_a}, 32'h0);
        chk("reset.dat", {24'h0, dat_b}, 32'h0);
        check_stats("reset");
        nrst = 1'b1;
        repeat (2) idle_beat();

        // "123456789" with its known FCS
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        send(0, -1);
        check_frame("chk9", 1'b1);

        frm[2] = 8'h00;
        send(0, -1);
        check_frame("chk9_bad", 1'b1);
        check_stats("after_chk9");

        make_good(60);
        send(0, -1);
        check_frame("len64", 1'b1);

        frm.delete();
        repeat (3) frm.push_back(8'($urandom));
        send(2, -1);
        check_frame("len3", 1'b1);

        frm = '{8'($urandom)};
        send(0, -1);
        check_frame("len1", 1'b1);

        make_good(1);
        send(0, -1);
        check_frame("len5", 1'b1);

        make_good(60);
        send(5, -1);
        check_frame("len64_gaps", 1'b1);

        make_good(1515);
        send(0, -1);
        check_frame("len1519", 1'b1);

        make_good(96);
        err_idx = 50;
        send(1, -1);
        check_frame("phy_err", 1'b1);
        err_idx = -1;
        check_stats("mid");

        make_good(66);
        send(0, 20);
        check_frame("reset_mid", 1'b0);
        check_stats("after_reset");

        make_good(66);
        send(0, -1);
        check_frame("post_reset", 1'b1);

        for (int t = 0; t < 8; t++) begin
            nd = $urandom_range(0, 150);
            make_good(nd);
            if ($urandom_range(0, 2) == 0) begin
                frm[$urandom_range(0, frm.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 3) == 0) err_idx = $urandom_range(0, frm.size() - 1);
            send($urandom_range(0, 3), -1);
            check_frame($sformatf("rnd%0d", t), 1'b1);
            err_idx = -1;
        end
        check_stats("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
